// File: rtl/ones_pattern_gen_pkg.sv
// Shared constants, FSM state type and bit-counting helpers for the ones-pattern generator.
package ones_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    EMIT   = 2'd2
  } state_t;

  // Four-bit result so that a full word (8 ones) is representable.
  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  // Largest word with k ones: k ones packed against the MSB.
  function automatic logic [WIDTH-1:0] top_word(input logic [CNT_W-1:0] k);
    logic [WIDTH-1:0] ones;
    ones = '1;
    if (k == '0) begin
      return '0;
    end
    return ones << (WIDTH - int'(k));
  endfunction

endpackage

// File: rtl/ones_pattern_gen_if.sv
// Request/response bundle between a requester and the ones-pattern generator.
interface ones_pattern_gen_if;
  import ones_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] in_count;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             err;

  // Driver side: issues requests and consumes words.
  modport master (
    output in_valid, in_count, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, err
  );

  // Generator side.
  modport slave (
    input  in_valid, in_count, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, err
  );

endinterface

// File: rtl/ones_pattern_gen.sv
// Emits every 8-bit word with exactly k ones, in ascending order, one word per handshake.
module ones_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  ones_pattern_gen_if.slave bus
);
  import ones_pkg::*;

  state_t             r_state, w_state_next;
  logic [WIDTH-1:0]   r_cand, w_cand_next;
  logic [CNT_W-1:0]   r_k, w_k_next;
  logic [WIDTH-1:0]   r_data, w_data_next;
  logic               r_last, w_last_next;
  logic               r_err, w_err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cand  <= '0;
      r_k     <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cand  <= w_cand_next;
      r_k     <= w_k_next;
      r_data  <= w_data_next;
      r_last  <= w_last_next;
      r_err   <= w_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cand_next  = r_cand;
    w_k_next     = r_k;
    w_data_next  = r_data;
    w_last_next  = r_last;
    w_err_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_count > CNT_W'(WIDTH)) begin
            w_err_next = 1'b1;
          end else begin
            w_k_next     = bus.in_count;
            w_cand_next  = '0;
            w_state_next = SEARCH;
          end
        end
      end
      SEARCH: begin
        // TOP(k) always matches before cand can wrap.
        if (popcount(r_cand) == r_k) begin
          w_data_next  = r_cand;
          w_last_next  = (r_cand == top_word(r_k));
          w_state_next = EMIT;
        end else begin
          w_cand_next = r_cand + WIDTH'(1);
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (r_last) begin
            w_state_next = IDLE;
          end else begin
            w_cand_next  = r_cand + WIDTH'(1);
            w_state_next = SEARCH;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == EMIT);
  assign bus.busy      = (r_state != IDLE);
  assign bus.out_data  = r_data;
  assign bus.out_last  = r_last;
  assign bus.err       = r_err;

endmodule

// File: doc/ones_pattern_gen.md
ONES_PATTERN_GEN -- requirements
Module: ones_pattern_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, word width; only 8 is supported.
REQ-002 The block SHALL have parameter CNT_W, default 4, count width; only 4 is supported.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid  input  1  request valid.
REQ-006 The block SHALL have port in_ready  output  1  block accepts a request; high exactly when state is IDLE.
REQ-007 The block SHALL have port in_count  input  4  requested number of ones, k.
REQ-008 The block SHALL have port out_valid  output  1  out_data/out_last valid; high exactly when state is EMIT.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts the word.
REQ-010 The block SHALL have port out_data  output  8  word with exactly k ones.
REQ-011 The block SHALL have port out_last  output  1  marks the final word of the request.
REQ-012 The block SHALL have port busy  output  1  state is not IDLE.
REQ-013 The block SHALL have port err  output  1  one-cycle pulse when a request has k > 8.

Function
REQ-014 The block SHALL emit, in ascending numeric order, every 8-bit word whose popcount equals k, one word per output handshake; there are C(8,k) words in total.
REQ-015 The block SHALL implement states IDLE, SEARCH and EMIT.
REQ-016 In IDLE, on in_valid & in_ready with k <= 8, the block SHALL latch k, clear the candidate register cand to 0x00 and enter SEARCH.
REQ-017 In IDLE, on a handshake with k > 8, the block SHALL pulse err for exactly one cycle, stay in IDLE and produce no output.
REQ-018 In SEARCH, each clock SHALL examine one candidate: if popcount(cand) == k, register out_data <= cand and out_last <= (cand == TOP(k)), then enter EMIT; otherwise cand <= cand + 1.
REQ-019 TOP(k) SHALL equal ((1<<k)-1) << (8-k): 0x00 for k=0 and 0xFF for k=8.
REQ-020 In EMIT, out_data and out_last SHALL be held stable until out_valid & out_ready.
REQ-021 On an EMIT handshake with out_last=1, the block SHALL return to IDLE; otherwise it SHALL set cand <= cand + 1 and re-enter SEARCH.
REQ-022 cand SHALL never wrap, because TOP(k) always terminates the scan; cand is 8 bits wide.
REQ-023 The first out_valid SHALL rise (1<<k) clock edges after the accepting edge (k=0: 1 edge; k=2: 4 edges).
REQ-024 in_valid SHALL be ignored outside IDLE; in_count SHALL be sampled only on the accepting edge.
REQ-025 popcount SHALL be computed with a 4-bit result, so that value 8 is representable.

Reset
REQ-026 While rst_n is low, the block SHALL be forced immediately to state IDLE, with cand=0x00, k=0, out_data=0x00, out_last=0, err=0, and therefore out_valid=0, busy=0, in_ready=1.
REQ-027 Reset during SEARCH or EMIT SHALL abandon the request without emitting a further word; the first edge after release SHALL see IDLE.

Structure
REQ-028 Shared package ones_pkg SHALL hold the WIDTH/CNT_W constants, the state enum (IDLE, SEARCH, EMIT), the popcount function (8-bit in, 4-bit out) and the TOP(k) function.
REQ-029 The block SHALL contain no sub-module; popcount SHALL be obtained from the ones_pkg function.
REQ-030 All outputs except in_ready, out_valid and busy SHALL be registered; those three SHALL be decoded from the registered state only.

Verification
REQ-031 k=2 with out_ready held at 1 -> 28 words, 0x03, 0x05, 0x06, 0x09, ... 0xC0; out_last is set only on 0xC0; each word has popcount 2.
REQ-032 k=0 -> a single word 0x00 with out_last=1, out_valid high 1 edge after acceptance, then IDLE.
REQ-033 k=8 -> a single word 0xFF with out_last=1 after a 256-edge first-output latency; k=9 -> an err pulse of exactly 1 cycle, no out_valid, in_ready stays 1.
REQ-034 k=4 with random out_ready backpressure -> 70 words, out_data/out_last stable while stalled, no word lost or duplicated, last word 0xF0.
REQ-035 Reset asserted in EMIT during k=3 -> out_valid drops asynchronously; after release a new k=1 request yields 0x01, 0x02, ... 0x80.
